// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous memory port between the
// MPU-table refill master (m0, read-only) and the CPU (m1, read/write).
module mem_port_arbiter #(
   parameter int MEM_WORDS       = 1024,
   parameter int MPU_START_ADDR  = 768,
   parameter int MPU_TABLE_WORDS = 81,
   parameter int MEM_LAT         = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic [21:0] m0_addr,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [21:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [3:0]  mem_wen,
   output logic [21:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic [1:0]  grant,
   output logic        table_dirty
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;
   localparam logic [31:0] TBL_LO      = MPU_START_ADDR;
   localparam logic [31:0] TBL_HI      = MPU_START_ADDR + MPU_TABLE_WORDS - 1;
   localparam logic [1:0]  LAT         = MEM_LAT[1:0];

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  grant_q, grant_d;
   logic        last_m1_q, last_m1_d;
   logic [21:0] addr_q, addr_d;
   logic [3:0]  wen_q, wen_d;
   logic [31:0] wdata_q, wdata_d;
   logic        oor_q, oor_d;
   logic        is_write_q, is_write_d;
   logic        dirty_q, dirty_d;
   logic [31:0] m0_rdata_q, m0_rdata_d;
   logic [31:0] m1_rdata_q, m1_rdata_d;

   logic        pick_m1;
   logic [21:0] req_addr;
   logic [31:0] req_addr_w;
   logic        req_in_range;
   logic [31:0] rvalue;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      grant_d    = grant_q;
      last_m1_d  = last_m1_q;
      addr_d     = addr_q;
      wen_d      = '0;
      wdata_d    = wdata_q;
      oor_d      = oor_q;
      is_write_d = is_write_q;
      dirty_d    = dirty_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;

      // Tie goes to whichever port was not served last.
      pick_m1      = m1_valid && (!m0_valid || !last_m1_q);
      req_addr     = pick_m1 ? m1_addr : m0_addr;
      req_addr_w   = {10'd0, req_addr};
      req_in_range = (req_addr_w < MEM_WORDS_U);
      rvalue       = (oor_q || is_write_q) ? 32'd0 : mem_rdata;

      case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               state_d    = ACCESS;
               cnt_d      = 2'd0;
               grant_d    = pick_m1 ? 2'b10 : 2'b01;
               last_m1_d  = pick_m1;
               addr_d     = req_addr;
               oor_d      = !req_in_range;
               is_write_d = pick_m1 && (m1_wstrb != 4'd0);
               dirty_d    = pick_m1 && req_in_range && (m1_wstrb != 4'd0) &&
                            (req_addr_w >= TBL_LO) && (req_addr_w <= TBL_HI);
               if (pick_m1) begin
                  wdata_d = m1_wdata;
               end
               if (pick_m1 && req_in_range) begin
                  wen_d = m1_wstrb;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == LAT) begin
               state_d = RESP;
               if (grant_q[0]) begin
                  m0_rdata_d = rvalue;
               end else begin
                  m1_rdata_d = rvalue;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // Reset forces last grant to m1 so m0 wins the first tie.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         grant_q    <= 2'b00;
         last_m1_q  <= 1'b1;
         addr_q     <= '0;
         wen_q      <= '0;
         wdata_q    <= '0;
         oor_q      <= 1'b0;
         is_write_q <= 1'b0;
         dirty_q    <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         grant_q    <= grant_d;
         last_m1_q  <= last_m1_d;
         addr_q     <= addr_d;
         wen_q      <= wen_d;
         wdata_q    <= wdata_d;
         oor_q      <= oor_d;
         is_write_q <= is_write_d;
         dirty_q    <= dirty_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign grant       = grant_q;
   assign m0_ready    = (state_q == RESP) && grant_q[0];
   assign m1_ready    = (state_q == RESP) && grant_q[1];
   assign m1_err      = (state_q == RESP) && grant_q[1] && oor_q;
   assign table_dirty = (state_q == RESP) && dirty_q;
   assign mem_wen     = wen_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign m0_rdata    = m0_rdata_q;
   assign m1_rdata    = m1_rdata_q;

endmodule
